// File: rtl/float_types_pkg.sv
// Shared single-precision float format, FSM encoding and helpers for the
// sequential FP units.
package float_types_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } float_point_num;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_ALIGN = 3'd2,
    ST_ADD   = 3'd3,
    ST_NORM  = 3'd4,
    ST_DONE  = 3'd5
  } fsm_state_e;

  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

  function automatic logic is_nan(input float_point_num x);
    return (x.exp == FP_EXP_MAX) && (x.mant != '0);
  endfunction

  function automatic logic is_inf(input float_point_num x);
    return (x.exp == FP_EXP_MAX) && (x.mant == '0);
  endfunction

endpackage

// File: rtl/fp_special_case_detect.sv
// Combinational NaN/Inf/zero screening of a + b_eff, where b_eff already
// carries the inverted subtrahend sign.
module fp_special_case_detect
  import float_types_pkg::*;
(
  input  float_point_num a_i,
  input  float_point_num b_i,
  output logic           special_o,
  output float_point_num res_o,
  output logic           status_o
);

  always_comb begin
    special_o = 1'b1;
    res_o     = '0;
    status_o  = 1'b0;
    if (is_nan(a_i) || is_nan(b_i)) begin
      res_o    = FP_QNAN;
      status_o = 1'b1;
    end else if (is_inf(a_i) && is_inf(b_i) && (a_i.sign != b_i.sign)) begin
      res_o    = FP_QNAN;
      status_o = 1'b1;
    end else if (is_inf(a_i)) begin
      res_o    = '{sign: a_i.sign, exp: FP_EXP_MAX, mant: '0};
      status_o = 1'b1;
    end else if (is_inf(b_i)) begin
      res_o    = '{sign: b_i.sign, exp: FP_EXP_MAX, mant: '0};
      status_o = 1'b1;
    end else if (b_i.exp == '0) begin
      // Denormals are flushed: a denormal minuend collapses to its signed zero.
      res_o = (a_i.exp == '0) ? '{sign: a_i.sign, exp: '0, mant: '0} : a_i;
    end else if (a_i.exp == '0) begin
      res_o = b_i;
    end else begin
      special_o = 1'b0;
    end
  end

endmodule

// File: rtl/seq_fp_subtractor.sv
// Multi-cycle single-precision subtractor (a - b): one alignment or
// normalisation bit per cycle behind valid/ready handshakes.
module seq_fp_subtractor
  import float_types_pkg::*;
#(
  parameter int EXP_W     = 8,
  parameter int MANT_W    = 23,
  parameter int ALIGN_SAT = 25
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  float_point_num a_i,
  input  float_point_num b_i,
  input  logic           vld_i,
  output logic           rdy_o,
  output float_point_num res_o,
  output logic           status_o,
  output logic           vld_o,
  input  logic           rdy_i
);

  localparam int SIG_W  = MANT_W + 1;
  localparam int SUM_W  = MANT_W + 2;
  localparam int DIFF_W = $clog2(ALIGN_SAT + 1);

  fsm_state_e        state_q, state_d;
  float_point_num    a_q, a_d, b_q, b_d;
  logic              sign_x_q, sign_x_d;
  logic              eff_sub_q, eff_sub_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [SIG_W-1:0]  mant_x_q, mant_x_d;
  logic [SIG_W-1:0]  mant_y_q, mant_y_d;
  logic [DIFF_W-1:0] diff_q, diff_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  float_point_num    res_q, res_d;
  logic              status_q, status_d;

  logic              spec_hit;
  float_point_num    spec_res;
  logic              spec_status;
  logic              a_ge_b;
  float_point_num    op_x, op_y;
  logic [EXP_W-1:0]  exp_gap;
  logic [DIFF_W-1:0] gap_sat;
  logic [EXP_W-1:0]  exp_inc;

  fp_special_case_detect u_special (
    .a_i       (a_q),
    .b_i       (b_q),
    .special_o (spec_hit),
    .res_o     (spec_res),
    .status_o  (spec_status)
  );

  // Ties keep a as the larger operand.
  assign a_ge_b  = {a_q.exp, a_q.mant} >= {b_q.exp, b_q.mant};
  assign op_x    = a_ge_b ? a_q : b_q;
  assign op_y    = a_ge_b ? b_q : a_q;
  assign exp_gap = op_x.exp - op_y.exp;
  assign gap_sat = (exp_gap > EXP_W'(ALIGN_SAT)) ? DIFF_W'(ALIGN_SAT) : exp_gap[DIFF_W-1:0];
  assign exp_inc = exp_q + EXP_W'(1);

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sign_x_d  = sign_x_q;
    eff_sub_d = eff_sub_q;
    exp_d     = exp_q;
    mant_x_d  = mant_x_q;
    mant_y_d  = mant_y_q;
    diff_d    = diff_q;
    sum_d     = sum_q;
    res_d     = res_q;
    status_d  = status_q;
    case (state_q)
      ST_IDLE: begin
        if (vld_i) begin
          a_d     = a_i;
          b_d     = '{sign: ~b_i.sign, exp: b_i.exp, mant: b_i.mant};
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (spec_hit) begin
          res_d    = spec_res;
          status_d = spec_status;
          state_d  = ST_DONE;
        end else begin
          sign_x_d  = op_x.sign;
          eff_sub_d = a_q.sign ^ b_q.sign;
          exp_d     = op_x.exp;
          mant_x_d  = {1'b1, op_x.mant};
          mant_y_d  = {1'b1, op_y.mant};
          diff_d    = gap_sat;
          status_d  = 1'b0;
          state_d   = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        if (diff_q == '0) begin
          state_d = ST_ADD;
        end else begin
          mant_y_d = mant_y_q >> 1;
          diff_d   = diff_q - DIFF_W'(1);
        end
      end
      ST_ADD: begin
        sum_d   = eff_sub_q ? ({1'b0, mant_x_q} - {1'b0, mant_y_q})
                            : ({1'b0, mant_x_q} + {1'b0, mant_y_q});
        state_d = ST_NORM;
      end
      ST_NORM: begin
        if (sum_q == '0) begin
          res_d   = '0;
          state_d = ST_DONE;
        end else if (sum_q[SUM_W-1]) begin
          sum_d = sum_q >> 1;
          exp_d = exp_inc;
          if (exp_inc == FP_EXP_MAX) begin
            res_d    = '{sign: sign_x_q, exp: FP_EXP_MAX, mant: '0};
            status_d = 1'b1;
            state_d  = ST_DONE;
          end
        end else if (sum_q[SUM_W-2]) begin
          res_d   = '{sign: sign_x_q, exp: exp_q, mant: sum_q[MANT_W-1:0]};
          state_d = ST_DONE;
        end else begin
          sum_d = sum_q << 1;
          exp_d = exp_q - EXP_W'(1);
          // Underflow past the smallest normal exponent flushes to signed zero.
          if (exp_q == EXP_W'(1)) begin
            res_d   = '{sign: sign_x_q, exp: '0, mant: '0};
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (rdy_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sign_x_q  <= 1'b0;
      eff_sub_q <= 1'b0;
      exp_q     <= '0;
      mant_x_q  <= '0;
      mant_y_q  <= '0;
      diff_q    <= '0;
      sum_q     <= '0;
      res_q     <= '0;
      status_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sign_x_q  <= sign_x_d;
      eff_sub_q <= eff_sub_d;
      exp_q     <= exp_d;
      mant_x_q  <= mant_x_d;
      mant_y_q  <= mant_y_d;
      diff_q    <= diff_d;
      sum_q     <= sum_d;
      res_q     <= res_d;
      status_q  <= status_d;
    end
  end

  assign rdy_o    = (state_q == ST_IDLE);
  assign vld_o    = (state_q == ST_DONE);
  assign res_o    = res_q;
  assign status_o = status_q;

endmodule

// File: tb/tb_seq_fp_subtractor.sv
// Directed bench for seq_fp_subtractor: arithmetic reference model plus a
// per-cycle compare process on handshake, result and latency.
module tb_seq_fp_subtractor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        vld_i = 1'b0, rdy_i = 1'b1;
  logic        rdy_o, status, vld_o;
  logic [31:0] res;

  int checks = 0, errors = 0;
  int cyc = 0, acc_cyc = 0;
  logic busy = 1'b0;
  logic [31:0] exp_res = '0;
  logic        exp_st = 1'b0;
  int          exp_lat = 0;

  always #5 clk = ~clk;

  seq_fp_subtractor dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .a_i      (a),
    .b_i      (b),
    .vld_i    (vld_i),
    .rdy_o    (rdy_o),
    .res_o    (res),
    .status_o (status),
    .vld_o    (vld_o),
    .rdy_i    (rdy_i)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h, required %08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: a - b from the float rules in plain integer arithmetic.
  function automatic void model(input logic [31:0] av, input logic [31:0] bv,
                                output logic [31:0] r, output logic s, output int lat);
    logic sa, sb, sx, sy, done;
    int ea, eb, ex, ey, d, e, n;
    longint fx, fy, mx, my, sum;
    sa = av[31]; ea = int'(av[30:23]);
    sb = ~bv[31]; eb = int'(bv[30:23]);
    r = '0; s = 1'b0; lat = 2;
    if ((ea == 255 && av[22:0] != 0) || (eb == 255 && bv[22:0] != 0)) begin
      r = 32'h7FC00000; s = 1'b1;
    end else if (ea == 255 && eb == 255 && sa != sb) begin
      r = 32'h7FC00000; s = 1'b1;
    end else if (ea == 255) begin
      r = {sa, 8'hFF, 23'h0}; s = 1'b1;
    end else if (eb == 255) begin
      r = {sb, 8'hFF, 23'h0}; s = 1'b1;
    end else if (eb == 0) begin
      r = (ea == 0) ? {sa, 31'h0} : av;
    end else if (ea == 0) begin
      r = {sb, bv[30:0]};
    end else begin
      if (av[30:0] >= bv[30:0]) begin
        sx = sa; ex = ea; fx = longint'(av[22:0]); sy = sb; ey = eb; fy = longint'(bv[22:0]);
      end else begin
        sx = sb; ex = eb; fx = longint'(bv[22:0]); sy = sa; ey = ea; fy = longint'(av[22:0]);
      end
      d = ex - ey;
      if (d > 25) d = 25;
      mx = fx + 64'd8388608;
      my = (fy + 64'd8388608) >> d;
      sum = (sx == sy) ? mx + my : mx - my;
      e = ex; n = 0; done = 1'b0;
      while (!done) begin
        n++;
        if (sum == 0) begin
          r = '0; done = 1'b1;
        end else if (sum >= 64'd16777216) begin
          sum = sum / 2; e++;
          if (e == 255) begin r = {sx, 8'hFF, 23'h0}; s = 1'b1; done = 1'b1; end
        end else if (sum >= 64'd8388608) begin
          r = {sx, 8'(e), 23'(sum)}; done = 1'b1;
        end else begin
          sum = sum * 2; e--;
          if (e == 0) begin r = {sx, 31'h0}; done = 1'b1; end
        end
      end
      lat = 4 + d + n;
    end
  endfunction

  // Model-side handshake tracking: acceptance and handoff follow the model.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) busy <= 1'b0;
    else if (!busy && vld_i) begin
      busy    <= 1'b1;
      acc_cyc <= cyc + 1;
    end else if (busy && rdy_i && (cyc >= acc_cyc + exp_lat - 1)) busy <= 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) begin
        check("vld_o", {31'b0, vld_o}, {31'b0, (cyc >= acc_cyc + exp_lat - 1)});
        check("rdy_o_busy", {31'b0, rdy_o}, 32'd0);
        if (vld_o) begin
          check("res_o", res, exp_res);
          check("status_o", {31'b0, status}, {31'b0, exp_st});
        end
      end else begin
        check("vld_o_idle", {31'b0, vld_o}, 32'd0);
        check("rdy_o_idle", {31'b0, rdy_o}, 32'd1);
      end
    end
  end

  task automatic wait_idle(input int budget);
    int i = 0;
    while (busy && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL handoff_timeout: still busy after %0d cycles, required idle", budget);
    end
  endtask

  task automatic start_op(input logic [31:0] aa, input logic [31:0] bb);
    model(aa, bb, exp_res, exp_st, exp_lat);
    a = aa; b = bb; vld_i = 1'b1;
    @(posedge clk); #1;
    vld_i = 1'b0;
  endtask

  task automatic run_op(input logic [31:0] aa, input logic [31:0] bb);
    start_op(aa, bb);
    wait_idle(exp_lat + 10);
    $display("op %08h - %08h : res_o=%08h status_o=%0b model %08h/%0b latency %0d",
             aa, bb, res, status, exp_res, exp_st, exp_lat);
  endtask

  task automatic pin(input logic [31:0] aa, input logic [31:0] bb,
                     input logic [31:0] r_req, input logic s_req, input int lat_req);
    logic [31:0] r; logic s; int lat;
    model(aa, bb, r, s, lat);
    check("model_res", r, r_req);
    check("model_status", {31'b0, s}, {31'b0, s_req});
    check("model_latency", 32'(lat), 32'(lat_req));
  endtask

  initial begin
    #1;
    check("reset_vld_o", {31'b0, vld_o}, 32'd0);
    check("reset_res_o", res, 32'h0);
    check("reset_status_o", {31'b0, status}, 32'd0);

    pin(32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 6);
    pin(32'h3F800000, 32'h3F400000, 32'h3E800000, 1'b0, 8);
    pin(32'h40000000, 32'hC0000000, 32'h40800000, 1'b0, 6);
    pin(32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 5);
    pin(32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b1, 2);
    pin(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1'b1, 5);
    pin(32'h00000001, 32'h3F800000, 32'hBF800000, 1'b0, 2);
    pin(32'h3F800000, 32'h2B800000, 32'h3F800000, 1'b0, 30);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(32'h40400000, 32'h3F800000);
    run_op(32'h3F800000, 32'h3F400000);
    run_op(32'h40000000, 32'hC0000000);
    run_op(32'h3F800000, 32'h3F800000);
    run_op(32'h7F800000, 32'h7F800000);
    run_op(32'h7F7FFFFF, 32'hFF7FFFFF);
    run_op(32'h00000001, 32'h3F800000);
    run_op(32'h3FC00000, 32'h40200000);
    run_op(32'h3F800000, 32'h2B800000);
    run_op(32'h7FC00001, 32'h3F800000);
    run_op(32'h3F800000, 32'h7F800000);
    run_op(32'h80000001, 32'h00000000);
    run_op(32'h00800001, 32'h00800000);

    // Backpressure: result held five cycles, a stray vld_i must be ignored.
    rdy_i = 1'b0;
    start_op(32'h40400000, 32'h3F800000);
    repeat (exp_lat - 1 + 5) @(posedge clk);
    #1;
    a = 32'h3F800000; b = 32'h3F800000; vld_i = 1'b1;
    @(posedge clk); #1;
    vld_i = 1'b0;
    rdy_i = 1'b1;
    wait_idle(4);
    $display("op 40400000 - 3F800000 (backpressure) : res_o=%08h status_o=%0b model %08h/%0b",
             res, status, exp_res, exp_st);
    @(posedge clk); #1;

    // Reset in the middle of a long alignment.
    start_op(32'h3F800000, 32'h3727C5AC);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_vld_o", {31'b0, vld_o}, 32'd0);
    check("abort_res_o", res, 32'h0);
    check("abort_status_o", {31'b0, status}, 32'd0);
    $display("op 3F800000 - 3727C5AC aborted by reset : res_o=%08h vld_o=%0b", res, vld_o);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_rdy_o", {31'b0, rdy_o}, 32'd1);
    @(posedge clk); #1;
    run_op(32'h40400000, 32'h3F800000);
    run_op(32'h3F800000, 32'h3F400000);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

endmodule
